rst_gen_seq: RTL and testbench
==============================

Name: rst_gen_seq

Overview:
- Reset generator and sequencer. It produces the reset that downstream `rst_sync` instances consume.
- Merges power-on reset, a software reset request and a watchdog reset request.
- Stretches each reset to a guaranteed minimum width.
- Releases NUM_OUT reset outputs in a fixed staggered order, one output every REL_GAP cycles, and records the cause of the last reset.
- Sits in the always-on clock/reset controller. Each output feeds a per-domain synchronizer.

Parameters:
- NUM_OUT, 3, number of sequenced active-low reset outputs; must be ≥ 1.
- MIN_PULSE, 16, cycles all outputs stay low in ASSERT; must be ≥ 2.
- REL_GAP, 8, cycles between consecutive output releases; must be ≥ 1.

Ports:
- clk_i  input  1  free-running always-on clock.
- rst_n_i  input  1  power-on reset. One clock; reset is asynchronous and active-low.
- sw_req_i  input  1  software reset request, sampled every cycle, level or pulse.
- wdt_req_i  input  1  watchdog reset request, sampled every cycle.
- ext_hold_i  input  1  while high, keeps the block in ASSERT after the minimum width has elapsed.
- rst_n_o  output  NUM_OUT  sequenced resets, registered, active-low; bit 0 is released first.
- busy_o  output  1  high whenever state is not RUN.
- cause_o  output  2  last reset cause: 0 = POR, 1 = SW, 2 = WDT, 3 = reserved.

Behaviour:
- States: ASSERT, RELEASE, RUN.
- Registers: one shared counter cnt of width $clog2(max(MIN_PULSE, REL_GAP) + 1), a release index idx, and cause.
- While rst_n_i is low (asynchronous):
  - state = ASSERT, cnt = 0, idx = 0
  - rst_n_o = all 0, busy_o = 1, cause_o = POR
- ASSERT:
  - All outputs low; cnt increments and saturates at MIN_PULSE-1.
  - When cnt == MIN_PULSE-1 and ext_hold_i == 0 and no request: next edge sets rst_n_o[0] = 1, cnt = 0, idx = 0.
  - Next state is RELEASE, or RUN if NUM_OUT == 1.
  - Minimum assert width is therefore exactly MIN_PULSE cycles.
- RELEASE:
  - cnt increments each cycle.
  - When cnt == REL_GAP-1: the next output bit (idx+1) is set high, idx increments and cnt = 0.
  - If that bit was NUM_OUT-1, next state is RUN.
  - rst_n_o[k] rises exactly k*REL_GAP cycles after rst_n_o[0].
- RUN: all outputs high, busy_o = 0, counter idle.
- Request handling (sw_req_i | wdt_req_i), in any state:
  - The next edge clears all rst_n_o to 0, sets state = ASSERT, cnt = 0, idx = 0, and updates cause.
  - A request during ASSERT restarts the minimum width.
  - A request on the same cycle as an ASSERT→RELEASE exit wins; the block stays in ASSERT with cnt = 0.
- Cause priority: WDT > SW when both requests arrive together. Cause holds until the next reset event and is not cleared on RUN.
- ext_hold_i:
  - Has no effect outside ASSERT.
  - During ASSERT, exit occurs on the first edge where cnt is saturated and ext_hold_i is low.
- rst_n_o is driven only from flops: no glitches, no combinational path from inputs.

Decomposition:
- rst_gen_pkg holds:
  - state enum: ASSERT, RELEASE, RUN
  - cause enum: RST_CAUSE_POR, RST_CAUSE_SW, RST_CAUSE_WDT
  - cause width localparam (2)
- No sub-module. The counter and FSM are inline.
- Per-domain synchronization is done by instantiating rst_sync externally on each rst_n_o bit.

Test Plan (defaults NUM_OUT=3, MIN_PULSE=16, REL_GAP=8):
- POR: deassert rst_n_i, no requests → rst_n_o = 3'b000 for 16 edges; bit0 rises on edge 16, bit1 on edge 24, bit2 on edge 32; busy_o falls with bit2; cause_o = 0.
- sw_req_i one-cycle pulse in RUN → next edge rst_n_o = 3'b000, busy_o = 1, cause_o = 1; same 16/8/8 release timing follows.
- sw_req_i and wdt_req_i high on the same cycle → cause_o = 2.
- sw_req_i pulse in RELEASE with rst_n_o = 3'b011 → next edge 3'b000; full 16-cycle assert before bit0 rises again.
- ext_hold_i high for 40 cycles from POR release → outputs held at 3'b000 until hold falls; bit0 rises on the first edge with ext_hold_i low.
- rst_n_i pulled low mid-RELEASE between clock edges → rst_n_o = 3'b000 and busy_o = 1 immediately, with no clock edge needed; cause_o = 0.

Source files
------------

// File: rtl/rst_gen_pkg.sv
// Shared types for the reset generator/sequencer: FSM states, reset-cause
// encoding and a small elaboration-time helper.
package rst_gen_pkg;

   localparam int CAUSE_W = 2;

   typedef enum logic [1:0] {
      ASSERT  = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2
   } state_e;

   // Encoding 3 is reserved and never produced.
   typedef enum logic [CAUSE_W-1:0] {
      RST_CAUSE_POR = 2'd0,
      RST_CAUSE_SW  = 2'd1,
      RST_CAUSE_WDT = 2'd2
   } cause_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rst_gen_seq.sv
// Reset generator and sequencer. Merges power-on, software and watchdog
// resets, stretches every reset to MIN_PULSE cycles, then releases the
// NUM_OUT active-low outputs in order, one every REL_GAP cycles. The last
// reset cause is kept until the next reset event.
module rst_gen_seq
   import rst_gen_pkg::*;
#(
   parameter int unsigned NUM_OUT   = 3,
   parameter int unsigned MIN_PULSE = 16,
   parameter int unsigned REL_GAP   = 8
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               sw_req_i,
   input  logic               wdt_req_i,
   input  logic               ext_hold_i,
   output logic [NUM_OUT-1:0] rst_n_o,
   output logic               busy_o,
   output logic [CAUSE_W-1:0] cause_o
);

   // One counter serves both the assert width and the release gap.
   localparam int CNT_MAX = max_int(int'(MIN_PULSE), int'(REL_GAP));
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

   localparam logic [CNT_W-1:0]   PULSE_LAST = CNT_W'(MIN_PULSE - 1);
   localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(REL_GAP - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_OUT - 1);
   localparam logic [NUM_OUT-1:0] OUT_FIRST  = NUM_OUT'(1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [IDX_W-1:0]     idx_nxt;
   logic [NUM_OUT-1:0]   rst_n_q, rst_n_d;
   logic                 busy_q, busy_d;
   cause_e               cause_q, cause_d;
   logic                 req;

   assign req = sw_req_i | wdt_req_i;

   // Next-state logic: sequencing first, then a request overrides everything.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rst_n_d = rst_n_q;
      busy_d  = busy_q;
      cause_d = cause_q;
      idx_nxt = idx_q + 1'b1;

      case (state_q)
         ASSERT: begin
            // Saturate so ext_hold_i can stretch the assert phase indefinitely.
            if (cnt_q != PULSE_LAST) begin
               cnt_d = cnt_q + 1'b1;
            end
            if ((cnt_q == PULSE_LAST) && !ext_hold_i) begin
               rst_n_d = OUT_FIRST;
               cnt_d   = '0;
               idx_d   = '0;
               if (NUM_OUT == 1) begin
                  state_d = RUN;
                  busy_d  = 1'b0;
               end else begin
                  state_d = RELEASE;
               end
            end
         end

         RELEASE: begin
            if (cnt_q == GAP_LAST) begin
               // Outputs form a thermometer code, so shifting in a one
               // releases exactly the next bit.
               rst_n_d = (rst_n_q << 1) | OUT_FIRST;
               idx_d   = idx_nxt;
               cnt_d   = '0;
               if (idx_nxt == IDX_LAST) begin
                  state_d = RUN;
                  busy_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         RUN: begin
            cnt_d = '0;
         end

         default: begin
            // Unreachable encoding: fall back to a fresh assert phase.
            state_d = ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            rst_n_d = '0;
            busy_d  = 1'b1;
         end
      endcase

      // A request wins over any transition in the same cycle, including
      // the ASSERT exit, and restarts the minimum width.
      if (req) begin
         state_d = ASSERT;
         cnt_d   = '0;
         idx_d   = '0;
         rst_n_d = '0;
         busy_d  = 1'b1;
         cause_d = wdt_req_i ? RST_CAUSE_WDT : RST_CAUSE_SW;
      end
   end

   // State and registered outputs; power-on reset forces outputs low at once.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ASSERT;
         cnt_q   <= '0;
         idx_q   <= '0;
         rst_n_q <= '0;
         busy_q  <= 1'b1;
         cause_q <= RST_CAUSE_POR;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rst_n_q <= rst_n_d;
         busy_q  <= busy_d;
         cause_q <= cause_d;
      end
   end

   assign rst_n_o = rst_n_q;
   assign busy_o  = busy_q;
   assign cause_o = cause_q;

endmodule

// File: tb/tb_rst_gen_seq.sv
// Directed bench for rst_gen_seq with default parameters (3 outputs,
// 16-cycle assert, 8-cycle release gap).
module tb_rst_gen_seq;

   logic       clk_i = 1'b0;
   logic       rst_n_i = 1'b0;
   logic       sw_req_i = 1'b0;
   logic       wdt_req_i = 1'b0;
   logic       ext_hold_i = 1'b0;
   logic [2:0] rst_n_o;
   logic       busy_o;
   logic [1:0] cause_o;

   int n_cmp = 0;
   int n_bad = 0;

   rst_gen_seq #(
      .NUM_OUT   (3),
      .MIN_PULSE (16),
      .REL_GAP   (8)
   ) dut (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .sw_req_i   (sw_req_i),
      .wdt_req_i  (wdt_req_i),
      .ext_hold_i (ext_hold_i),
      .rst_n_o    (rst_n_o),
      .busy_o     (busy_o),
      .cause_o    (cause_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic       sw;
      logic       wdt;
      logic       hold;
      int         ncyc;
      logic [2:0] exp_rst;
      logic       exp_busy;
      logic [1:0] exp_cause;
      string      name;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic sw, input logic wdt, input logic hold,
                               input int ncyc, input logic [2:0] r, input logic b,
                               input logic [1:0] c, input string name);
      vec_t v;
      v.sw = sw; v.wdt = wdt; v.hold = hold; v.ncyc = ncyc;
      v.exp_rst = r; v.exp_busy = b; v.exp_cause = c; v.name = name;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [2:0] er, input logic eb,
                        input logic [1:0] ec);
      n_cmp++;
      if (rst_n_o !== er) begin
         n_bad++;
         $display("FAIL %s rst_n_o: got %b want %b", name, rst_n_o, er);
      end
      n_cmp++;
      if (busy_o !== eb) begin
         n_bad++;
         $display("FAIL %s busy_o: got %b want %b", name, busy_o, eb);
      end
      n_cmp++;
      if (cause_o !== ec) begin
         n_bad++;
         $display("FAIL %s cause_o: got %0d want %0d", name, cause_o, ec);
      end
   endtask

   // Inputs change at the falling edge, outputs are sampled at the falling edge.
   task automatic run_vec(input vec_t v);
      sw_req_i   = v.sw;
      wdt_req_i  = v.wdt;
      ext_hold_i = v.hold;
      repeat (v.ncyc) @(posedge clk_i);
      @(negedge clk_i);
      check(v.name, v.exp_rst, v.exp_busy, v.exp_cause);
   endtask

   initial begin
      // POR release timing
      add(0,0,0,15,3'b000,1,0,"por_low15");
      add(0,0,0, 1,3'b001,1,0,"por_bit0_e16");
      add(0,0,0, 7,3'b001,1,0,"por_gap1");
      add(0,0,0, 1,3'b011,1,0,"por_bit1_e24");
      add(0,0,0, 7,3'b011,1,0,"por_gap2");
      add(0,0,0, 1,3'b111,0,0,"por_bit2_e32");
      add(0,0,0, 5,3'b111,0,0,"run_stable");
      // software pulse in RUN
      add(1,0,0, 1,3'b000,1,1,"sw_run");
      add(0,0,0,15,3'b000,1,1,"sw_low15");
      add(0,0,0, 1,3'b001,1,1,"sw_bit0");
      add(0,0,0, 8,3'b011,1,1,"sw_bit1");
      add(0,0,0, 8,3'b111,0,1,"sw_bit2");
      // simultaneous requests: watchdog wins
      add(1,1,0, 1,3'b000,1,2,"sw_wdt_both");
      add(0,0,0,16,3'b001,1,2,"both_bit0");
      add(0,0,0, 8,3'b011,1,2,"both_bit1");
      // software pulse mid-RELEASE
      add(1,0,0, 1,3'b000,1,1,"sw_in_release");
      add(0,0,0,15,3'b000,1,1,"rel_restart_low15");
      add(0,0,0, 1,3'b001,1,1,"rel_restart_bit0");
      add(0,0,0,16,3'b111,0,1,"rel_restart_run");
      // watchdog alone
      add(0,1,0, 1,3'b000,1,2,"wdt_run");
      add(0,0,0,16,3'b001,1,2,"wdt_bit0");
      add(0,0,0,16,3'b111,0,2,"wdt_run_again");
      // request during ASSERT restarts the width
      add(1,0,0, 1,3'b000,1,1,"sw_a");
      add(0,0,0,10,3'b000,1,1,"assert_mid");
      add(1,0,0, 1,3'b000,1,1,"sw_restart");
      add(0,0,0,15,3'b000,1,1,"restart_low15");
      add(0,0,0, 1,3'b001,1,1,"restart_bit0");
      add(0,0,0,16,3'b111,0,1,"restart_run");
      // request on the exit cycle blocks the exit
      add(1,0,0, 1,3'b000,1,1,"sw_b");
      add(0,0,0,15,3'b000,1,1,"exit_sat");
      add(1,0,0, 1,3'b000,1,1,"sw_on_exit");
      add(0,0,0,15,3'b000,1,1,"exit_low15");
      add(0,0,0, 1,3'b001,1,1,"exit_bit0");
      add(0,0,0,16,3'b111,0,1,"exit_run");
      // ext_hold ignored outside ASSERT
      add(0,0,1, 3,3'b111,0,1,"hold_in_run");
      add(1,0,0, 1,3'b000,1,1,"sw_c");
      add(0,0,0,16,3'b001,1,1,"hold_rel_bit0");
      add(0,0,1, 8,3'b011,1,1,"hold_in_release");
      add(0,0,0, 8,3'b111,0,1,"hold_rel_run");

      // reset state
      repeat (3) @(negedge clk_i);
      check("por_reset", 3'b000, 1'b1, 2'd0);
      rst_n_i = 1'b1;
      foreach (vecs[i]) run_vec(vecs[i]);

      // async POR from RUN with cause SW clears cause immediately
      @(negedge clk_i);
      ext_hold_i = 1'b1;
      rst_n_i    = 1'b0;
      #1;
      check("por_async_from_run", 3'b000, 1'b1, 2'd0);

      // ext_hold high for 40 cycles from POR release
      @(negedge clk_i);
      rst_n_i = 1'b1;
      repeat (40) @(posedge clk_i);
      @(negedge clk_i);
      check("hold_40", 3'b000, 1'b1, 2'd0);
      ext_hold_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      check("hold_drop_bit0", 3'b001, 1'b1, 2'd0);
      repeat (16) @(posedge clk_i);
      @(negedge clk_i);
      check("hold_run", 3'b111, 1'b0, 2'd0);

      // async POR mid-RELEASE, between clock edges
      sw_req_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      sw_req_i = 1'b0;
      check("sw_d", 3'b000, 1'b1, 2'd1);
      repeat (24) @(posedge clk_i);
      @(negedge clk_i);
      check("mid_release", 3'b011, 1'b1, 2'd1);
      @(posedge clk_i);
      #3 rst_n_i = 1'b0;
      #1;
      check("async_mid_release", 3'b000, 1'b1, 2'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      @(negedge clk_i);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
